// File: rtl/fifo_sync_lvl.sv
// Single-clock FIFO with occupancy level, almost-full/almost-empty flags, FWFT or registered read, flush.
// Define FIFO_SYNC_LVL_ERR_EN to add sticky OVERFLOW/UNDERFLOW flags and the ERR_CLR input.
module fifo_sync_lvl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1,
  parameter int FWFT       = 1,
  parameter int LW         = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             WRITE,
  input  logic [WIDTH-1:0] WDATA,
  output logic             FULL,
  output logic             AFULL,
  input  logic             READ,
  output logic [WIDTH-1:0] RDATA,
  output logic             EMPTY,
  output logic             AEMPTY,
  output logic [LW-1:0]    LEVEL
`ifdef FIFO_SYNC_LVL_ERR_EN
  ,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  input  logic             ERR_CLR
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_LVL);
  localparam logic [LW-1:0] LVL_AEMPT = LW'(AEMPTY_LVL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full, empty, push, pop;

  assign full   = (level_q == LVL_FULL);
  assign empty  = (level_q == '0);
  assign FULL   = full;
  assign EMPTY  = empty;
  assign AFULL  = (level_q >= LVL_AFULL);
  assign AEMPTY = (level_q <= LVL_AEMPT);
  assign LEVEL  = level_q;

  // Acceptance uses pre-edge flags, so a pop never frees room for a push while full.
  assign push = WRITE & ~full;
  assign pop  = READ & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (FLUSH) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
      if (pop)  rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !FLUSH) mem_q[wptr_q] <= WDATA;
  end

  if (FWFT != 0) begin : g_fwft
    assign RDATA = empty ? '0 : mem_q[rptr_q];
  end else begin : g_reg
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Registered read data only reloads on a real pop and otherwise holds, even across flush.
    always_comb begin
      rdata_d = rdata_q;
      if (pop && !FLUSH) rdata_d = mem_q[rptr_q];
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) rdata_q <= '0;
      else       rdata_q <= rdata_d;
    end

    assign RDATA = rdata_q;
  end

`ifdef FIFO_SYNC_LVL_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = (WRITE & full & ~FLUSH) | (ovf_q & ~ERR_CLR);
    udf_d = (READ & empty & ~FLUSH) | (udf_q & ~ERR_CLR);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;
`endif

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// Bench for fifo_sync_lvl: a DEPTH=4 FWFT instance and a DEPTH=3 registered-read instance.
// Extra sticky-flag checks are compiled in when FIFO_SYNC_LVL_ERR_EN is defined.
module tb_fifo_sync_lvl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       a_flush, a_write, a_read;
  logic [7:0] a_wdata, a_rdata;
  logic       a_full, a_afull, a_empty, a_aempty;
  logic [2:0] a_level;
  logic       b_flush, b_write, b_read;
  logic [7:0] b_wdata, b_rdata;
  logic       b_full, b_afull, b_empty, b_aempty;
  logic [1:0] b_level;
`ifdef FIFO_SYNC_LVL_ERR_EN
  logic       a_ovf, a_udf, a_err_clr;
  logic       b_ovf, b_udf, b_err_clr;
`endif

  int checks = 0;
  int errors = 0;
  int mlev_a = 0;
  int mlev_b = 0;
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  logic [7:0] b_last = 8'h00;

  always #5 CLK = ~CLK;

  fifo_sync_lvl #(.WIDTH(8), .DEPTH(4)) u_a (
    .CLK(CLK), .RESET(RESET), .FLUSH(a_flush), .WRITE(a_write), .WDATA(a_wdata),
    .FULL(a_full), .AFULL(a_afull), .READ(a_read), .RDATA(a_rdata),
    .EMPTY(a_empty), .AEMPTY(a_aempty), .LEVEL(a_level)
`ifdef FIFO_SYNC_LVL_ERR_EN
    , .OVERFLOW(a_ovf), .UNDERFLOW(a_udf), .ERR_CLR(a_err_clr)
`endif
  );

  fifo_sync_lvl #(.WIDTH(8), .DEPTH(3), .FWFT(0)) u_b (
    .CLK(CLK), .RESET(RESET), .FLUSH(b_flush), .WRITE(b_write), .WDATA(b_wdata),
    .FULL(b_full), .AFULL(b_afull), .READ(b_read), .RDATA(b_rdata),
    .EMPTY(b_empty), .AEMPTY(b_aempty), .LEVEL(b_level)
`ifdef FIFO_SYNC_LVL_ERR_EN
    , .OVERFLOW(b_ovf), .UNDERFLOW(b_udf), .ERR_CLR(b_err_clr)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (a_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", a_level); end
    checks++; if ({a_empty, a_aempty, a_full, a_afull} !== 4'b1100) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 1100", {a_empty, a_aempty, a_full, a_afull}); end
    checks++; if (a_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata_a: got %0h expected 0", a_rdata); end
    checks++; if (b_rdata !== 8'h00 || b_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_b: got rdata %0h empty %b expected 0/1", b_rdata, b_empty); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 5; i++) begin
      a_write = 1'b1;
      a_wdata = 8'(i);
      if (mlev_a < 4) begin sb_a.push_back(8'(i)); mlev_a++; end
      tick();
      checks++; if (a_level !== 3'(mlev_a)) begin errors++; $display("[TB] FAIL fill_level: got %0d expected %0d", a_level, mlev_a); end
      checks++; if (a_afull !== (mlev_a >= 3)) begin errors++; $display("[TB] FAIL fill_afull: got %b expected %b at level %0d", a_afull, (mlev_a >= 3), mlev_a); end
      checks++; if (a_full !== (mlev_a == 4)) begin errors++; $display("[TB] FAIL fill_full: got %b expected %b", a_full, (mlev_a == 4)); end
      checks++; if (a_aempty !== (mlev_a <= 1)) begin errors++; $display("[TB] FAIL fill_aempty: got %b expected %b", a_aempty, (mlev_a <= 1)); end
      if (i == 1) begin
        checks++; if (a_rdata !== 8'h01 || a_empty !== 1'b0) begin errors++; $display("[TB] FAIL fwft_first: got %0h empty %b expected 01/0", a_rdata, a_empty); end
      end
    end
    a_write = 1'b0;
  endtask

  task automatic test_drain();
    logic [7:0] exp;
    while (sb_a.size() > 0) begin
      exp = sb_a.pop_front();
      checks++; if (a_rdata !== exp) begin errors++; $display("[TB] FAIL drain_data: got %0h expected %0h", a_rdata, exp); end
      a_read = 1'b1;
      tick();
      mlev_a--;
    end
    a_read = 1'b0;
    checks++; if (a_empty !== 1'b1 || a_level !== 3'd0) begin errors++; $display("[TB] FAIL drain_end: got empty %b level %0d expected 1/0", a_empty, a_level); end
  endtask

  task automatic test_underflow_ignored();
    a_read = 1'b1;
    tick();
    a_read = 1'b0;
    checks++; if (a_level !== 3'd0 || a_empty !== 1'b1) begin errors++; $display("[TB] FAIL empty_read: got level %0d empty %b expected 0/1", a_level, a_empty); end
  endtask

  task automatic test_registered_read();
    logic [7:0] exp;
    for (int i = 0; i < 3; i++) begin
      b_write = 1'b1;
      b_wdata = 8'h11 + 8'(i);
      sb_b.push_back(b_wdata);
      mlev_b++;
      tick();
    end
    b_write = 1'b0;
    checks++; if (b_full !== 1'b1 || b_level !== 2'd3) begin errors++; $display("[TB] FAIL regrd_full: got full %b level %0d expected 1/3", b_full, b_level); end
    checks++; if (b_rdata !== 8'h00) begin errors++; $display("[TB] FAIL regrd_before_pop: got %0h expected 0", b_rdata); end
    while (sb_b.size() > 0) begin
      exp = sb_b.pop_front();
      b_read = 1'b1;
      tick();
      mlev_b--;
      b_last = exp;
      checks++; if (b_rdata !== exp) begin errors++; $display("[TB] FAIL regrd_data: got %0h expected %0h", b_rdata, exp); end
    end
    b_read = 1'b0;
    tick();
    checks++; if (b_rdata !== b_last || b_empty !== 1'b1) begin errors++; $display("[TB] FAIL regrd_hold: got %0h empty %b expected %0h/1", b_rdata, b_empty, b_last); end
  endtask

  task automatic test_stream();
    logic [7:0] cnt = 8'h60;
    logic [7:0] exp;
    logic       did_pop;
    for (int c = 0; c < 20; c++) begin
      checks++; if (b_level !== 2'(mlev_b) || b_empty !== (mlev_b == 0)) begin errors++; $display("[TB] FAIL stream_level: got %0d empty %b expected %0d", b_level, b_empty, mlev_b); end
      b_write = 1'b1;
      b_wdata = cnt;
      b_read  = (mlev_b != 0);
      did_pop = 1'b0;
      if (b_read) begin exp = sb_b.pop_front(); did_pop = 1'b1; mlev_b--; end
      if (mlev_b + (did_pop ? 1 : 0) < 3) begin sb_b.push_back(cnt); cnt++; mlev_b++; end
      tick();
      if (did_pop) begin
        b_last = exp;
        checks++; if (b_rdata !== exp) begin errors++; $display("[TB] FAIL stream_data: got %0h expected %0h", b_rdata, exp); end
      end
    end
    b_write = 1'b0;
    while (sb_b.size() > 0) begin
      exp = sb_b.pop_front();
      b_read = 1'b1;
      tick();
      mlev_b--;
      b_last = exp;
      checks++; if (b_rdata !== exp) begin errors++; $display("[TB] FAIL stream_tail: got %0h expected %0h", b_rdata, exp); end
    end
    b_read = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      a_write = 1'b1;
      a_wdata = 8'h21 + 8'(i);
      sb_a.push_back(a_wdata);
      mlev_a++;
      tick();
    end
    a_wdata = 8'h23;
    a_read  = 1'b1;
    checks++; if (a_rdata !== sb_a[0]) begin errors++; $display("[TB] FAIL b2b_pop: got %0h expected %0h", a_rdata, sb_a[0]); end
    void'(sb_a.pop_front());
    sb_a.push_back(8'h23);
    tick();
    a_write = 1'b0;
    a_read  = 1'b0;
    checks++; if (a_level !== 3'd2) begin errors++; $display("[TB] FAIL b2b_level: got %0d expected 2", a_level); end
    test_drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      a_write = 1'b1;
      a_wdata = 8'h31 + 8'(i);
      tick();
    end
    a_wdata = 8'h34;
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    a_write = 1'b0;
    checks++; if (a_level !== 3'd0 || a_empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_a: got level %0d empty %b expected 0/1", a_level, a_empty); end
    a_write = 1'b1;
    a_wdata = 8'h35;
    tick();
    a_write = 1'b0;
    sb_a.push_back(8'h35);
    mlev_a = 1;
    checks++; if (a_level !== 3'd1) begin errors++; $display("[TB] FAIL flush_refill: got level %0d expected 1", a_level); end
    test_drain();
    for (int i = 0; i < 2; i++) begin
      b_write = 1'b1;
      b_wdata = 8'h41 + 8'(i);
      tick();
    end
    b_write = 1'b0;
    b_flush = 1'b1;
    b_read  = 1'b1;
    tick();
    b_flush = 1'b0;
    b_read  = 1'b0;
    checks++; if (b_level !== 2'd0 || b_rdata !== b_last) begin errors++; $display("[TB] FAIL flush_b: got level %0d rdata %0h expected 0/%0h", b_level, b_rdata, b_last); end
  endtask

`ifdef FIFO_SYNC_LVL_ERR_EN
  task automatic test_errors();
    a_err_clr = 1'b1;
    tick();
    a_err_clr = 1'b0;
    a_read = 1'b1;
    tick();
    a_read = 1'b0;
    checks++; if (a_udf !== 1'b1 || a_ovf !== 1'b0) begin errors++; $display("[TB] FAIL udf_set: got udf %b ovf %b expected 1/0", a_udf, a_ovf); end
    tick();
    tick();
    checks++; if (a_udf !== 1'b1) begin errors++; $display("[TB] FAIL udf_sticky: got %b expected 1", a_udf); end
    a_read = 1'b1;
    a_err_clr = 1'b1;
    tick();
    a_read = 1'b0;
    checks++; if (a_udf !== 1'b1) begin errors++; $display("[TB] FAIL udf_set_wins: got %b expected 1", a_udf); end
    tick();
    a_err_clr = 1'b0;
    checks++; if (a_udf !== 1'b0) begin errors++; $display("[TB] FAIL udf_clear: got %b expected 0", a_udf); end
    for (int i = 0; i < 5; i++) begin
      a_write = 1'b1;
      a_wdata = 8'h70 + 8'(i);
      tick();
    end
    a_write = 1'b0;
    checks++; if (a_ovf !== 1'b1 || a_level !== 3'd4) begin errors++; $display("[TB] FAIL ovf_set: got ovf %b level %0d expected 1/4", a_ovf, a_level); end
    a_err_clr = 1'b1;
    tick();
    a_err_clr = 1'b0;
    a_write = 1'b1;
    a_flush = 1'b1;
    tick();
    a_write = 1'b0;
    a_flush = 1'b0;
    checks++; if (a_ovf !== 1'b0 || a_level !== 3'd0) begin errors++; $display("[TB] FAIL ovf_flush: got ovf %b level %0d expected 0/0", a_ovf, a_level); end
    mlev_a = 0;
  endtask
`endif

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      a_write = 1'b1;
      a_wdata = 8'h51 + 8'(i);
      tick();
    end
    checks++; if (a_level !== 3'd2) begin errors++; $display("[TB] FAIL mid_prefill: got %0d expected 2", a_level); end
    RESET = 1'b1;
    #1;
    checks++; if (a_level !== 3'd0 || a_empty !== 1'b1 || b_rdata !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset: got level %0d empty %b rdata_b %0h expected 0/1/0", a_level, a_empty, b_rdata); end
    #2;
    RESET = 1'b0;
    a_write = 1'b0;
    tick();
    checks++; if (a_level !== 3'd0) begin errors++; $display("[TB] FAIL mid_after: got %0d expected 0", a_level); end
    sb_a.delete();
    mlev_a = 0;
  endtask

  initial begin
    RESET = 1'b1;
    {a_flush, a_write, a_read, a_wdata} = '0;
    {b_flush, b_write, b_read, b_wdata} = '0;
`ifdef FIFO_SYNC_LVL_ERR_EN
    a_err_clr = 1'b0;
    b_err_clr = 1'b0;
`endif
    #12;
    test_reset();
    #1;
    RESET = 1'b0;
    tick();
    test_fill();
    test_drain();
    test_underflow_ignored();
    test_registered_read();
    test_stream();
    test_back_to_back();
    test_flush();
`ifdef FIFO_SYNC_LVL_ERR_EN
    test_errors();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
